// File: rtl/hh_pkg.sv
// Shared types and helpers for the Hodgkin-Huxley neuron array.
//   gate_t   : Q0.8 unsigned gating variable (m, h, n)
//   state_t  : step sequencer states
//   wide_t   : internal signed working width for the voltage/current datapath
//   helpers  : gate product, gate clamp/relaxation, voltage saturation,
//              refractory counter width
package hh_pkg;

    typedef logic [7:0] gate_t;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    // Wide enough that no intermediate product or sum can wrap for W <= 36.
    localparam int XW = 48;
    typedef logic signed [XW-1:0] wide_t;

    localparam gate_t M_RST = 8'd13;
    localparam gate_t H_RST = 8'd153;
    localparam gate_t N_RST = 8'd80;

    // Half-activation voltages of the gating curves, in voltage LSBs.
    localparam int VH_M = -640;
    localparam int VH_H = -1040;
    localparam int VH_N = -880;

    function automatic int refr_width(input int refract);
        return (refract < 2) ? 1 : $clog2(refract + 1);
    endfunction

    // (a*b*c*d) >> 24 : conductance from four Q0.8 gates, result Q0.8.
    function automatic gate_t gate_prod4(input gate_t a, input gate_t b,
                                         input gate_t c, input gate_t d);
        logic [31:0] p;
        p = 32'(a) * 32'(b) * 32'(c) * 32'(d);
        return p[31:24];
    endfunction

    function automatic gate_t clamp_gate(input wide_t x);
        if (x < 0)
            return 8'd0;
        else if (x > wide_t'(255))
            return 8'd255;
        else
            return x[7:0];
    endfunction

    // First-order relaxation toward x_inf; the floor shift always moves the
    // value toward x_inf, so the result stays inside 0..255.
    function automatic gate_t gate_step(input gate_t x, input gate_t xinf,
                                        input int tau);
        logic signed [9:0] d;
        logic signed [9:0] s;
        d = $signed({2'b00, xinf}) - $signed({2'b00, x});
        s = $signed({2'b00, x}) + (d >>> tau);
        return s[7:0];
    endfunction

    // Clamp to the signed range of a w-bit voltage.
    function automatic wide_t sat_v(input wide_t x, input int w);
        wide_t hi;
        wide_t lo;
        hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
        lo = -hi - wide_t'(1);
        if (x > hi)
            return hi;
        else if (x < lo)
            return lo;
        else
            return x;
    endfunction

endpackage

// File: rtl/hh_channel_dp.sv
// Combinational single-channel update: one Euler step of membrane voltage,
// gating relaxation and refractory handling, all from the old state.
//   i_v/i_m/i_h/i_n/i_refr : current channel state
//   i_stim                 : signed stimulus current for this step
//   o_v/o_m/o_h/o_n/o_refr : next channel state
//   o_spike                : threshold crossing in this step
module hh_channel_dp
    import hh_pkg::*;
#(
    parameter int W         = 16,
    parameter int FRAC      = 4,
    parameter int V_RESET   = -1120,
    parameter int THRESH    = 0,
    parameter int E_NA      = 800,
    parameter int E_K       = -1232,
    parameter int E_L       = -1040,
    parameter int SH_NA     = 0,
    parameter int SH_K      = 1,
    parameter int SH_L      = 3,
    parameter int DT_SHIFT  = 2,
    parameter int TAU_SHIFT = 2,
    parameter int REFRACT   = 3,
    parameter int RW        = 2
) (
    input  logic signed [W-1:0]  i_v,
    input  gate_t                i_m,
    input  gate_t                i_h,
    input  gate_t                i_n,
    input  logic [RW-1:0]        i_refr,
    input  logic signed [W-1:0]  i_stim,
    output logic signed [W-1:0]  o_v,
    output gate_t                o_m,
    output gate_t                o_h,
    output gate_t                o_n,
    output logic [RW-1:0]        o_refr,
    output logic                 o_spike
);

    wide_t w_v, w_gna, w_gk, w_ina, w_ik, w_il, w_i, w_vc;
    wide_t w_dm, w_dh, w_dn;

    assign w_v   = XW'(i_v);
    assign w_gna = XW'($signed({1'b0, gate_prod4(i_m, i_m, i_m, i_h)}));
    assign w_gk  = XW'($signed({1'b0, gate_prod4(i_n, i_n, i_n, i_n)}));

    assign w_ina = (w_gna * (w_v - XW'(E_NA))) >>> (8 + SH_NA);
    assign w_ik  = (w_gk  * (w_v - XW'(E_K)))  >>> (8 + SH_K);
    assign w_il  = (w_v - XW'(E_L)) >>> SH_L;
    assign w_i   = XW'(i_stim) - w_ina - w_ik - w_il;
    assign w_vc  = sat_v(w_v + (w_i >>> DT_SHIFT), W);

    // Steady-state gate targets: 4 Q0.8 counts per mV away from the midpoint.
    assign w_dm = (w_v - XW'(VH_M)) >>> FRAC;
    assign w_dh = (w_v - XW'(VH_H)) >>> FRAC;
    assign w_dn = (w_v - XW'(VH_N)) >>> FRAC;

    assign o_m = gate_step(i_m, clamp_gate(XW'(128) + (w_dm <<< 2)), TAU_SHIFT);
    assign o_h = gate_step(i_h, clamp_gate(XW'(128) - (w_dh <<< 2)), TAU_SHIFT);
    assign o_n = gate_step(i_n, clamp_gate(XW'(128) + (w_dn <<< 2)), TAU_SHIFT);

    always_comb begin
        o_v     = $signed(w_vc[W-1:0]);
        o_refr  = i_refr;
        o_spike = 1'b0;
        if (i_refr != '0) begin
            // Clamped during refractory; gating keeps evolving regardless.
            o_v    = W'(V_RESET);
            o_refr = i_refr - RW'(1);
        end else if (w_vc >= XW'(THRESH)) begin
            o_spike = 1'b1;
            o_v     = W'(V_RESET);
            o_refr  = RW'(REFRACT);
        end
    end

endmodule

// File: rtl/hh_neuron_array.sv
// Time-multiplexed array of N_CH Hodgkin-Huxley neurons sharing one update
// datapath. An accepted step walks channels 0..N_CH-1 one per cycle, then
// publishes the spike vector with a one-cycle done pulse.
//   clk, rst_n  : clock, synchronous active-low reset
//   step_valid  : request one time step (ignored while busy)
//   step_ready  : high only when idle
//   stim_flat   : per-channel signed stimulus, ch0 in LSBs, captured on accept
//   done        : one-cycle pulse, N_CH+1 cycles after accept
//   spike       : per-channel spike flags of the last completed step
//   v_flat      : stored channel voltages, ch0 in LSBs
module hh_neuron_array
    import hh_pkg::*;
#(
    parameter int N_CH      = 4,
    parameter int W         = 16,
    parameter int FRAC      = 4,
    parameter int V_REST    = -1040,
    parameter int V_RESET   = -1120,
    parameter int THRESH    = 0,
    parameter int E_NA      = 800,
    parameter int E_K       = -1232,
    parameter int E_L       = -1040,
    parameter int SH_NA     = 0,
    parameter int SH_K      = 1,
    parameter int SH_L      = 3,
    parameter int DT_SHIFT  = 2,
    parameter int TAU_SHIFT = 2,
    parameter int REFRACT   = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 step_valid,
    output logic                 step_ready,
    input  logic [N_CH*W-1:0]    stim_flat,
    output logic                 done,
    output logic [N_CH-1:0]      spike,
    output logic [N_CH*W-1:0]    v_flat
);

    localparam int RW = refr_width(REFRACT);
    localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;

    state_t              r_state, w_state_nxt;
    logic [IW-1:0]       r_idx;
    logic signed [W-1:0] r_v [N_CH];
    gate_t               r_m [N_CH];
    gate_t               r_h [N_CH];
    gate_t               r_n [N_CH];
    logic [RW-1:0]       r_refr [N_CH];
    logic [N_CH*W-1:0]   r_stim;
    logic [N_CH-1:0]     r_spk_acc;
    logic [N_CH-1:0]     r_spike;
    logic                r_done;

    logic signed [W-1:0] w_v_nxt;
    gate_t               w_m_nxt, w_h_nxt, w_n_nxt;
    logic [RW-1:0]       w_refr_nxt;
    logic                w_spike;

    hh_channel_dp #(
        .W(W), .FRAC(FRAC), .V_RESET(V_RESET), .THRESH(THRESH),
        .E_NA(E_NA), .E_K(E_K), .E_L(E_L),
        .SH_NA(SH_NA), .SH_K(SH_K), .SH_L(SH_L),
        .DT_SHIFT(DT_SHIFT), .TAU_SHIFT(TAU_SHIFT),
        .REFRACT(REFRACT), .RW(RW)
    ) u_dp (
        .i_v    (r_v[r_idx]),
        .i_m    (r_m[r_idx]),
        .i_h    (r_h[r_idx]),
        .i_n    (r_n[r_idx]),
        .i_refr (r_refr[r_idx]),
        .i_stim ($signed(r_stim[r_idx*W +: W])),
        .o_v    (w_v_nxt),
        .o_m    (w_m_nxt),
        .o_h    (w_h_nxt),
        .o_n    (w_n_nxt),
        .o_refr (w_refr_nxt),
        .o_spike(w_spike)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (step_valid) w_state_nxt = CALC;
            CALC:    if (r_idx == IW'(N_CH - 1)) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_idx     <= '0;
            r_stim    <= '0;
            r_spk_acc <= '0;
            r_spike   <= '0;
            r_done    <= 1'b0;
            for (int c = 0; c < N_CH; c++) begin
                r_v[c]    <= W'(V_REST);
                r_m[c]    <= M_RST;
                r_h[c]    <= H_RST;
                r_n[c]    <= N_RST;
                r_refr[c] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            // Registered so the pulse lands together with the new spike vector.
            r_done  <= (r_state == DONE);
            case (r_state)
                IDLE: if (step_valid) begin
                    r_stim <= stim_flat;
                    r_idx  <= '0;
                end
                CALC: begin
                    r_v[r_idx]       <= w_v_nxt;
                    r_m[r_idx]       <= w_m_nxt;
                    r_h[r_idx]       <= w_h_nxt;
                    r_n[r_idx]       <= w_n_nxt;
                    r_refr[r_idx]    <= w_refr_nxt;
                    r_spk_acc[r_idx] <= w_spike;
                    r_idx            <= r_idx + IW'(1);
                end
                DONE:    r_spike <= r_spk_acc;
                default: ;
            endcase
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_vout
        assign v_flat[c*W +: W] = r_v[c];
    end

    assign step_ready = (r_state == IDLE);
    assign done       = r_done;
    assign spike      = r_spike;

endmodule
